// File: rtl/uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_ctrl
// Description : Bus-attached UART with TX/RX FIFOs, a programmable bit
//               period, sticky error flags and a registered level interrupt.
//
//   Parameters : CLK_FREQ   - system clock frequency in Hz
//                BIT_RATE   - bit rate used to derive the reset BAUD value
//                DATA_BITS  - frame payload width (5..9)
//                FIFO_DEPTH - depth of each FIFO (power of two, >= 2)
//
//   Ports      : clk, rst_n           - clock, synchronous active-low reset
//                cyc_i, stb_i, we_i   - bus cycle, strobe, write enable
//                addr_i, data_i       - byte address ([4:2] decoded), wdata
//                data_o, ack_o        - registered read data, acknowledge
//                rxd, txd             - serial input / output
//                irq_o                - level interrupt
//
//   Optional   : define UART_CTRL_PARITY_EN to enable parity generation and
//                checking (CTRL bits 2-3). Without it frames carry no parity
//                bit and CTRL bits 2-3 read as zero.
//
//   Revision   : 1.0 - initial release
// ============================================================================
module uart_ctrl #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BIT_RATE   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    input  logic        rxd,
    output logic        txd,
    output logic        irq_o
);

    localparam int              c_AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0]     c_BAUD_RST  = 16'(CLK_FREQ / BIT_RATE - 1);
    localparam logic [3:0]      c_LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW + 1)'(1);

    localparam logic [2:0] c_REG_DATA     = 3'd0;
    localparam logic [2:0] c_REG_STATUS   = 3'd1;
    localparam logic [2:0] c_REG_CTRL     = 3'd2;
    localparam logic [2:0] c_REG_BAUD     = 3'd3;
    localparam logic [2:0] c_REG_IRQ_EN   = 3'd4;
    localparam logic [2:0] c_REG_IRQ_PEND = 3'd5;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic        r_ack;
    logic [31:0] r_data_o;
    logic [3:0]  r_ctrl;
    logic [15:0] r_baud;
    logic [2:0]  r_irq_en;
    logic        r_irq;
    logic        r_rx_ovr;
    logic        r_frame_err;
    logic        r_parity_err;
    logic        r_tx_ovf;

    logic        w_par_en;
    logic        w_par_odd;

`ifdef UART_CTRL_PARITY_EN
    assign w_par_en  = r_ctrl[2];
    assign w_par_odd = r_ctrl[3];
`else
    assign w_par_en  = 1'b0;
    assign w_par_odd = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Bus decode. Side effects (push/pop/W1C) happen on the request cycle,
    // the acknowledge and read data follow one cycle later.
    // ------------------------------------------------------------------
    logic       w_req;
    logic       w_wr;
    logic       w_rd;
    logic [2:0] w_sel;

    assign w_req = cyc_i & stb_i & ~r_ack;
    assign w_wr  = w_req & we_i;
    assign w_rd  = w_req & ~we_i;
    assign w_sel = addr_i[4:2];

    logic w_unused_bits;
    assign w_unused_bits = ^{addr_i, data_i};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_tx_mem [FIFO_DEPTH];
    logic [c_AW:0]        r_tx_wr;
    logic [c_AW:0]        r_tx_rd;
    logic                 w_tx_empty;
    logic                 w_tx_full;
    logic                 w_tx_push;
    logic                 w_tx_pop;
    logic                 w_tx_ovf_set;
    logic [DATA_BITS-1:0] w_tx_head;

    assign w_tx_empty   = (r_tx_wr == r_tx_rd);
    assign w_tx_full    = (r_tx_wr[c_AW] != r_tx_rd[c_AW]) &&
                          (r_tx_wr[c_AW-1:0] == r_tx_rd[c_AW-1:0]);
    assign w_tx_push    = w_wr && (w_sel == c_REG_DATA) && !w_tx_full;
    assign w_tx_ovf_set = w_wr && (w_sel == c_REG_DATA) && w_tx_full;
    assign w_tx_head    = r_tx_mem[r_tx_rd[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wr[c_AW-1:0]] <= data_i[DATA_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_wr <= '0;
            r_tx_rd <= '0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + c_PTR_ONE;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_rx_mem [FIFO_DEPTH];
    logic [c_AW:0]        r_rx_wr;
    logic [c_AW:0]        r_rx_rd;
    logic                 w_rx_empty;
    logic                 w_rx_full;
    logic                 w_rx_push;
    logic                 w_rx_pop;
    logic [DATA_BITS-1:0] w_rx_head;
    logic [DATA_BITS-1:0] r_rx_shift;

    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[c_AW] != r_rx_rd[c_AW]) &&
                        (r_rx_wr[c_AW-1:0] == r_rx_rd[c_AW-1:0]);
    assign w_rx_pop   = w_rd && (w_sel == c_REG_DATA) && !w_rx_empty;
    assign w_rx_head  = r_rx_mem[r_rx_rd[c_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wr[c_AW-1:0]] <= r_rx_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_wr <= '0;
            r_rx_rd <= '0;
        end else begin
            if (w_rx_push) r_rx_wr <= r_rx_wr + c_PTR_ONE;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // TX state machine. Bit period and parity setup are captured when a
    // frame starts so register writes never disturb a frame in flight.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    tx_state_t            r_tx_state;
    tx_state_t            w_tx_next;
    logic [15:0]          r_tx_cnt;
    logic [15:0]          r_tx_baud;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par_bit;
    logic                 r_tx_par_en;
    logic                 w_tx_tick;
    logic                 w_txd;
    logic                 w_tx_busy;

    assign w_tx_tick = (r_tx_cnt == r_tx_baud);
    assign w_tx_busy = (r_tx_state != TX_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        w_txd     = 1'b1;
        case (r_tx_state)
            TX_IDLE: begin
                if (r_ctrl[1] && !w_tx_empty) begin
                    w_tx_next = TX_START;
                    w_tx_pop  = 1'b1;
                end
            end
            TX_START: begin
                w_txd = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_txd = r_tx_shift[0];
                if (w_tx_tick && (r_tx_bit == c_LAST_BIT)) begin
                    w_tx_next = r_tx_par_en ? TX_PARITY : TX_STOP;
                end
            end
            TX_PARITY: begin
                w_txd = r_tx_par_bit;
                if (w_tx_tick) w_tx_next = TX_STOP;
            end
            TX_STOP: begin
                if (w_tx_tick) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_cnt     <= '0;
            r_tx_baud    <= '0;
            r_tx_bit     <= '0;
            r_tx_shift   <= '0;
            r_tx_par_bit <= 1'b0;
            r_tx_par_en  <= 1'b0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            if (w_tx_pop) begin
                r_tx_shift   <= w_tx_head;
                r_tx_baud    <= r_baud;
                r_tx_par_bit <= (^w_tx_head) ^ w_par_odd;
                r_tx_par_en  <= w_par_en;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt <= '0;
            if (r_tx_state == TX_DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_bit   <= r_tx_bit + 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
        end
    end

    assign txd = w_txd;

    // ------------------------------------------------------------------
    // RX synchroniser, edge detect and state machine. The start bit is
    // sampled half a period in; later samples are one full period apart,
    // so every sample lands near a bit centre.
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    rx_state_t   r_rx_state;
    rx_state_t   w_rx_next;
    logic [15:0] r_rx_cnt;
    logic [15:0] r_rx_baud;
    logic [3:0]  r_rx_bit;
    logic        r_rx_par_bit;
    logic        r_rx_par_en;
    logic        r_rx_par_odd;
    logic        w_rx_fall;
    logic [15:0] w_rx_half;
    logic        w_rx_mid_tick;
    logic        w_rx_tick;
    logic        w_rx_start;
    logic        w_rx_done;
    logic        w_rx_par_bad;
    logic        w_rx_good;
    logic        w_rx_frame_err;
    logic        w_rx_par_err;
    logic        w_rx_ovr_set;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
    assign w_rx_half     = 16'((17'(r_rx_baud) + 17'd1) >> 1);
    assign w_rx_mid_tick = (r_rx_cnt == w_rx_half);
    assign w_rx_tick     = (r_rx_cnt == r_rx_baud);
    assign w_rx_par_bad  = r_rx_par_en &&
                           (r_rx_par_bit != ((^r_rx_shift) ^ r_rx_par_odd));

    always_ff @(posedge clk) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_start = 1'b0;
        w_rx_done  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_ctrl[0] && w_rx_fall) begin
                    w_rx_next  = RX_START;
                    w_rx_start = 1'b1;
                end
            end
            RX_START: begin
                // A high start-bit sample is treated as line noise.
                if (w_rx_mid_tick) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_rx_tick && (r_rx_bit == c_LAST_BIT)) begin
                    w_rx_next = r_rx_par_en ? RX_PARITY : RX_STOP;
                end
            end
            RX_PARITY: begin
                if (w_rx_tick) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_next = RX_IDLE;
                    w_rx_done = 1'b1;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    assign w_rx_frame_err = w_rx_done && !r_rx_s2;
    assign w_rx_par_err   = w_rx_done && r_rx_s2 && w_rx_par_bad;
    assign w_rx_good      = w_rx_done && r_rx_s2 && !w_rx_par_bad;
    // A bus pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_rx_push      = w_rx_good && (!w_rx_full || w_rx_pop);
    assign w_rx_ovr_set   = w_rx_good && w_rx_full && !w_rx_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_cnt     <= '0;
            r_rx_baud    <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_par_en  <= 1'b0;
            r_rx_par_odd <= 1'b0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    if (w_rx_start) begin
                        r_rx_baud    <= r_baud;
                        r_rx_par_en  <= w_par_en;
                        r_rx_par_odd <= w_par_odd;
                    end
                end
                RX_START: begin
                    if (w_rx_mid_tick) r_rx_cnt <= '0;
                    else               r_rx_cnt <= r_rx_cnt + 16'd1;
                end
                default: begin
                    if (w_rx_tick) begin
                        r_rx_cnt <= '0;
                        if (r_rx_state == RX_DATA) begin
                            r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                            r_rx_bit   <= r_rx_bit + 4'd1;
                        end
                        if (r_rx_state == RX_PARITY) r_rx_par_bit <= r_rx_s2;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control registers and sticky flags (set wins over W1C clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ctrl   <= '0;
            r_baud   <= c_BAUD_RST;
            r_irq_en <= '0;
        end else if (w_wr) begin
            case (w_sel)
`ifdef UART_CTRL_PARITY_EN
                c_REG_CTRL:   r_ctrl <= data_i[3:0];
`else
                c_REG_CTRL:   r_ctrl <= {2'b00, data_i[1:0]};
`endif
                c_REG_BAUD:   r_baud   <= data_i[15:0];
                c_REG_IRQ_EN: r_irq_en <= data_i[2:0];
                default: ;
            endcase
        end
    end

    logic w_status_wr;
    assign w_status_wr = w_wr && (w_sel == c_REG_STATUS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_ovr     <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_tx_ovf     <= 1'b0;
        end else begin
            if (w_rx_ovr_set)                    r_rx_ovr <= 1'b1;
            else if (w_status_wr && data_i[5])   r_rx_ovr <= 1'b0;
            if (w_rx_frame_err)                  r_frame_err <= 1'b1;
            else if (w_status_wr && data_i[6])   r_frame_err <= 1'b0;
            if (w_rx_par_err)                    r_parity_err <= 1'b1;
            else if (w_status_wr && data_i[7])   r_parity_err <= 1'b0;
            if (w_tx_ovf_set)                    r_tx_ovf <= 1'b1;
            else if (w_status_wr && data_i[8])   r_tx_ovf <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read mux, acknowledge and interrupt
    // ------------------------------------------------------------------
    logic [31:0] w_status;
    logic [2:0]  w_irq_pend;
    logic [31:0] w_rd_data;

    assign w_status = {23'd0, r_tx_ovf, r_parity_err, r_frame_err, r_rx_ovr,
                       w_tx_busy, w_tx_full, w_tx_empty, w_rx_full, w_rx_empty};
    assign w_irq_pend = {(r_rx_ovr | r_frame_err | r_parity_err | r_tx_ovf),
                         w_tx_empty, !w_rx_empty};

    always_comb begin
        w_rd_data = '0;
        case (w_sel)
            c_REG_DATA: begin
                if (!w_rx_empty) begin
                    w_rd_data[31]            = 1'b1;
                    w_rd_data[DATA_BITS-1:0] = w_rx_head;
                end
            end
            c_REG_STATUS:   w_rd_data = w_status;
            c_REG_CTRL:     w_rd_data = {28'd0, r_ctrl};
            c_REG_BAUD:     w_rd_data = {16'd0, r_baud};
            c_REG_IRQ_EN:   w_rd_data = {29'd0, r_irq_en};
            c_REG_IRQ_PEND: w_rd_data = {29'd0, w_irq_pend};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack    <= 1'b0;
            r_data_o <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_ack    <= w_req;
            r_data_o <= w_rd ? w_rd_data : 32'd0;
            r_irq    <= |(w_irq_pend & r_irq_en);
        end
    end

    assign ack_o  = r_ack;
    assign data_o = r_data_o;
    assign irq_o  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_uart_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_ctrl
// Description : Directed self-checking bench for uart_ctrl (default params).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_ctrl;

    localparam logic [31:0] c_A_DATA     = 32'h00;
    localparam logic [31:0] c_A_STATUS   = 32'h04;
    localparam logic [31:0] c_A_CTRL     = 32'h08;
    localparam logic [31:0] c_A_BAUD     = 32'h0C;
    localparam logic [31:0] c_A_IRQ_EN   = 32'h10;
    localparam logic [31:0] c_A_IRQ_PEND = 32'h14;
    localparam logic [31:0] c_A_UNMAPPED = 32'h18;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        cyc_i  = 1'b0;
    logic        stb_i  = 1'b0;
    logic        we_i   = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        ack_o;
    logic        rxd    = 1'b1;
    logic        txd;
    logic        irq_o;

    int n_checks = 0;
    int n_fail   = 0;

    uart_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cyc_i  (cyc_i),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .addr_i (addr_i),
        .data_i (data_i),
        .data_o (data_o),
        .ack_o  (ack_o),
        .rxd    (rxd),
        .txd    (txd),
        .irq_o  (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; addr_i = a; data_i = d;
        @(posedge clk); #1;
        check("write_ack", {31'd0, ack_o}, 32'd1);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = a;
        @(posedge clk); #1;
        check("read_ack", {31'd0, ack_o}, 32'd1);
        d = data_o;
        cyc_i = 1'b0; stb_i = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // One bit period at BAUD=15 is 16 clocks.
    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b,
                              input logic has_par, input logic par_b);
        @(posedge clk); #1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_b);
        send_bit(stop_b);
        rxd = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0]  tx_exp;
        logic [10:0] par_exp;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_txd",  {31'd0, txd},   32'd1);
        check("rst_ack",  {31'd0, ack_o}, 32'd0);
        check("rst_irq",  {31'd0, irq_o}, 32'd0);
        check("rst_data", data_o,         32'd0);
        read_check("rst_baud",   c_A_BAUD,   32'd216);
        read_check("rst_ctrl",   c_A_CTRL,   32'd0);
        read_check("rst_status", c_A_STATUS, 32'h05);
        read_check("rst_irqen",  c_A_IRQ_EN, 32'd0);
        read_check("rst_pend",   c_A_IRQ_PEND, 32'h2);

        // ---------------- ack is a single-cycle pulse ----------------
        @(posedge clk); #1;
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; addr_i = c_A_STATUS;
        @(posedge clk); #1;
        check("ack_pulse1", {31'd0, ack_o}, 32'd1);
        check("ack_data",   data_o,         32'h05);
        @(posedge clk); #1;
        check("ack_gap",    {31'd0, ack_o}, 32'd0);
        @(posedge clk); #1;
        check("ack_pulse2", {31'd0, ack_o}, 32'd1);
        cyc_i = 1'b0; stb_i = 1'b0;

        // ---------------- unmapped address, CTRL masking ----------------
        bus_write(c_A_UNMAPPED, 32'hFFFF_FFFF);
        read_check("unmapped_rd", c_A_UNMAPPED, 32'd0);
        read_check("unmapped_ctrl", c_A_CTRL, 32'd0);
        bus_write(c_A_CTRL, 32'hFFFF_FFFF);
`ifdef UART_CTRL_PARITY_EN
        read_check("ctrl_mask", c_A_CTRL, 32'h0F);
`else
        read_check("ctrl_mask", c_A_CTRL, 32'h03);
`endif
        bus_write(c_A_CTRL, 32'd0);
        bus_write(c_A_BAUD, 32'd15);
        read_check("baud_rd", c_A_BAUD, 32'd15);
        bus_write(c_A_CTRL, 32'd3);

        // ---------------- TX 0x55 waveform and busy window ----------------
        tx_exp = {1'b1, 8'h55, 1'b0};
        bus_write(c_A_DATA, 32'h55);
        @(posedge clk); #1;
        check("tx_start_edge", {31'd0, txd}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            check("tx_bit", {31'd0, txd}, {31'd0, tx_exp[k]});
            if (k < 9) begin
                repeat (16) @(posedge clk);
                #1;
            end
        end
        repeat (5) @(posedge clk);
        #1;
        read_check("tx_busy_last", c_A_STATUS, 32'h15);
        read_check("tx_busy_done", c_A_STATUS, 32'h05);

        // ---------------- RX 0xA3 ----------------
        send_frame(8'hA3, 1'b1, 1'b0, 1'b0);
        read_check("rx_pend", c_A_IRQ_PEND, 32'h3);
        read_check("rx_a3",    c_A_DATA, 32'h8000_00A3);
        read_check("rx_empty", c_A_DATA, 32'h0000_0000);

        // ---------------- framing error and interrupt ----------------
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        read_check("ferr_status", c_A_STATUS,   32'h45);
        read_check("ferr_pend",   c_A_IRQ_PEND, 32'h6);
        check("ferr_irq_off", {31'd0, irq_o}, 32'd0);
        bus_write(c_A_IRQ_EN, 32'd4);
        @(posedge clk); #1;
        check("ferr_irq_on", {31'd0, irq_o}, 32'd1);
        bus_write(c_A_STATUS, 32'h40);
        read_check("ferr_clear", c_A_STATUS, 32'h05);
        check("ferr_irq_clr", {31'd0, irq_o}, 32'd0);
        bus_write(c_A_IRQ_EN, 32'd0);

        // ---------------- RX fill and overrun ----------------
        for (int i = 0; i < 32; i++) send_frame(8'(i + 1), 1'b1, 1'b0, 1'b0);
        send_frame(8'hEE, 1'b1, 1'b0, 1'b0);
        read_check("ovr_status", c_A_STATUS, 32'h26);
        read_check("ovr_first",  c_A_DATA,   32'h8000_0001);
        bus_write(c_A_STATUS, 32'h20);
        read_check("ovr_clear",  c_A_STATUS, 32'h04);
        for (int i = 1; i < 32; i++) begin
            bus_read(c_A_DATA, v);
            check("drain", v, 32'h8000_0000 | 32'(i + 1));
        end
        read_check("drain_empty",  c_A_DATA,   32'd0);
        read_check("drain_status", c_A_STATUS, 32'h05);

`ifdef UART_CTRL_PARITY_EN
        // ---------------- parity TX/RX ----------------
        bus_write(c_A_CTRL, 32'h07);
        par_exp = {1'b1, 1'b1, 8'h07, 1'b0};
        bus_write(c_A_DATA, 32'h07);
        @(posedge clk); #1;
        repeat (8) @(posedge clk);
        #1;
        for (int k = 0; k < 11; k++) begin
            check("par_tx_bit", {31'd0, txd}, {31'd0, par_exp[k]});
            if (k < 10) begin
                repeat (16) @(posedge clk);
                #1;
            end
        end
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        read_check("par_err", c_A_STATUS, 32'h85);
        read_check("par_drop", c_A_DATA, 32'd0);
        bus_write(c_A_STATUS, 32'h80);
        bus_write(c_A_CTRL, 32'h03);
`else
        par_exp = '0;
`endif

        // ---------------- TX overflow, then reset mid-frame ----------------
        bus_write(c_A_CTRL, 32'd0);
        for (int i = 0; i < 33; i++) bus_write(c_A_DATA, 32'(i));
        read_check("txovf_status", c_A_STATUS, 32'h109);
        bus_write(c_A_CTRL, 32'd2);
        repeat (40) @(posedge clk);
        #1;
        check("midtx_busy_txd", {31'd0, txd}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rstmid_txd", {31'd0, txd}, 32'd1);
        check("rstmid_ack", {31'd0, ack_o}, 32'd0);
        rst_n = 1'b1;
        read_check("rstmid_status", c_A_STATUS, 32'h05);
        read_check("rstmid_ctrl",   c_A_CTRL,   32'd0);
        read_check("rstmid_baud",   c_A_BAUD,   32'd216);
        repeat (20) @(posedge clk);
        #1;
        check("rstmid_idle_txd", {31'd0, txd}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
